// File: rtl/sum_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator_pkg
// Brief    : Shared datapath width and state encoding for sum_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package sum_accumulator_pkg;

    localparam int DATA_W = 8;

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    typedef enum logic [0:0] {
        S_ACCUM = ST_ACCUM,
        S_HOLD  = ST_HOLD
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module   : adder
// Brief    : Combinational DATA_W-bit ripple-carry adder, modulo 2**DATA_W.
// Revision : 1.0 - initial release
// ============================================================================
module adder
    import sum_accumulator_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_sum
);

    // Carry out of the top bit is intentionally not produced.
    logic [DATA_W-1:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry[i];
        if (i < DATA_W - 1) begin : g_carry
            assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

endmodule
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : sum_accumulator
// Brief    : Multi-term packet accumulator around the ripple adder, with
//            valid/ready input and output streams.
// Revision : 1.0 - initial release
// ============================================================================
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_sum,
    output logic              out_ovf,
    output logic              out_trunc,
    output logic [CNT_W-1:0]  out_count
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_TERMS);

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;
    logic                r_trunc;

    logic [DATA_W-1:0]   w_sum;
    logic [CNT_W-1:0]    w_count_inc;
    logic                w_accept;
    logic                w_end;
    logic                w_pop;

    adder u_adder (
        .i_a   (r_acc),
        .i_b   (in_data),
        .o_sum (w_sum)
    );

    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_end        = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_ACCUM: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (in_last || (w_count_inc == c_max)) begin
                        w_end        = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_pop        = 1'b1;
                    w_state_next = S_ACCUM;
                end
            end
            default: w_state_next = S_ACCUM;
        endcase
    end

    // Without a carry port, a wrapped result (new < old) is the carry-out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_trunc <= 1'b0;
        end else if (w_pop) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_trunc <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= w_count_inc;
            r_ovf   <= r_ovf | (w_sum < r_acc);
            if (w_end) begin
                r_trunc <= ~in_last;
            end
        end
    end

    // Gating with rst keeps every output low while reset is held.
    assign in_ready  = (r_state == S_ACCUM) && !rst;
    assign out_valid = (r_state == S_HOLD);
    assign out_sum   = r_acc;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;
    assign out_trunc = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_accumulator
// Brief    : Directed self-checking bench with a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

    localparam int MAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;
    logic       out_trunc;
    logic [7:0] out_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: true (unwrapped) packet total, term count, pending flag.
    int m_total;
    int m_count;
    bit m_hold;
    bit m_trunc;

    sum_accumulator #(.MAX_TERMS(MAX), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_trunc (out_trunc),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_total <= 0;
            m_count <= 0;
            m_hold  <= 1'b0;
            m_trunc <= 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_total <= 0;
                m_count <= 0;
                m_hold  <= 1'b0;
                m_trunc <= 1'b0;
            end
        end else if (in_valid) begin
            m_total <= m_total + int'(in_data);
            m_count <= m_count + 1;
            if (in_last || (m_count + 1 == MAX)) begin
                m_hold  <= 1'b1;
                m_trunc <= !in_last;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_in_ready", 32'(in_ready), 32'(!m_hold));
            check("model_out_valid", 32'(out_valid), 32'(m_hold));
            if (m_hold) begin
                check("model_sum", 32'(out_sum), 32'(m_total % 256));
                check("model_count", 32'(out_count), 32'(m_count));
                check("model_ovf", 32'(out_ovf), 32'(m_total > 255));
                check("model_trunc", 32'(out_trunc), 32'(m_trunc));
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) check("beat_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    // Called right after the accepting edge: result must already be visible.
    task automatic expect_result(input logic [7:0] s, input logic [7:0] c,
                                 input logic o, input logic t);
        @(negedge clk);
        check("lit_valid", 32'(out_valid), 32'd1);
        check("lit_sum", 32'(out_sum), 32'(s));
        check("lit_count", 32'(out_count), 32'(c));
        check("lit_ovf", 32'(out_ovf), 32'(o));
        check("lit_trunc", 32'(out_trunc), 32'(t));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        beat(8'h02, 1'b0);
        beat(8'h02, 1'b1);
        expect_result(8'h04, 8'd2, 1'b0, 1'b0);

        beat(8'h01, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("idle_sum", 32'(out_sum), 32'h01);
            check("idle_count", 32'(out_count), 32'd1);
            @(posedge clk);
            #1;
        end
        beat(8'h03, 1'b1);
        expect_result(8'h04, 8'd2, 1'b0, 1'b0);

        beat(8'h92, 1'b0);
        beat(8'hAB, 1'b1);
        expect_result(8'h3D, 8'd2, 1'b1, 1'b0);
        beat(8'h10, 1'b1);
        expect_result(8'h10, 8'd1, 1'b0, 1'b0);

        // Exactly MAX terms with in_last on the final one: not truncated.
        beat(8'hFF, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'h01, 1'b0);
        beat(8'h01, 1'b1);
        expect_result(8'h00, 8'd4, 1'b1, 1'b0);

        // Truncation, then a fifth beat stalled across a long HOLD.
        repeat (4) beat(8'h01, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_last  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(out_sum), 32'h04);
            check("hold_count", 32'(out_count), 32'd4);
            check("hold_trunc", 32'(out_trunc), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b1);
        expect_result(8'h03, 8'd2, 1'b0, 1'b0);

        // Asynchronous reset after 2 of 3 terms.
        beat(8'h07, 1'b0);
        beat(8'h08, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sum", 32'(out_sum), 32'd0);
        check("arst_count", 32'(out_count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(8'h05, 1'b1);
        expect_result(8'h05, 8'd1, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
